// File: rtl/chess_pkg.sv
// Shared constants for the chess timer game controller: state codes, player codes, minutes width.
package chess_pkg;

    localparam int unsigned MIN_W = 6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SET    = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_RUN_P1 = 3'd3;
    localparam logic [2:0] S_RUN_P2 = 3'd4;
    localparam logic [2:0] S_PAUSE  = 3'd5;
    localparam logic [2:0] S_FLAG   = 3'd6;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_ONE  = 2'b01;
    localparam logic [1:0] P_TWO  = 2'b10;

    // Minutes selection wraps from the maximum back to 1, never to 0.
    function automatic logic [MIN_W-1:0] next_minutes(input logic [MIN_W-1:0] cur,
                                                      input logic [MIN_W-1:0] max_min);
        return (cur >= max_min) ? MIN_W'(1) : cur + MIN_W'(1);
    endfunction

    function automatic logic is_run(input logic [2:0] st);
        return (st == S_RUN_P1) || (st == S_RUN_P2);
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts while run is high, holds otherwise, emits a registered
// tick on wrap; clear restarts the second.
module sec_tick #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/chess_game_ctrl.sv
// Chess timer play-state controller: set mode, clock loading, turn handover, pause, flag fall.
// Define CHESS_INCREMENT_EN to add the Fischer increment output inc and parameter INC_SEC.
module chess_game_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned MAX_MIN     = 60,
    parameter int unsigned DEFAULT_MIN = 5
`ifdef CHESS_INCREMENT_EN
    ,
    parameter int unsigned INC_SEC     = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_set,
    input  logic             btn_add,
    input  logic             btn_start,
    input  logic             btn_p1,
    input  logic             btn_p2,
    input  logic             zero1,
    input  logic             zero2,
    output logic             set_mode,
    output logic [MIN_W-1:0] minutes,
    output logic             load,
    output logic             tick,
    output logic [1:0]       player,
    output logic [1:0]       flag,
    output logic [2:0]       state
`ifdef CHESS_INCREMENT_EN
    ,
    output logic [1:0]       inc
`endif
);

    localparam logic [MIN_W-1:0] MIN_RESET = MIN_W'(DEFAULT_MIN);
    localparam logic [MIN_W-1:0] MIN_MAX   = MIN_W'(MAX_MIN);

    logic [2:0]       state_q, state_d;
    logic [MIN_W-1:0] minutes_q, minutes_d;
    logic [1:0]       flag_q, flag_d;
    logic [1:0]       saved_q, saved_d;
    logic [1:0]       player_q, player_d;
    logic             load_q, load_d;
    logic             set_mode_q;
    logic             pre_run, pre_clear;

    always_comb begin
        state_d   = state_q;
        minutes_d = minutes_q;
        flag_d    = flag_q;
        saved_d   = saved_q;
        load_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_set) begin
                    state_d = S_SET;
                end else if (btn_start) begin
                    state_d = S_READY;
                    load_d  = 1'b1;
                end
            end
            S_SET: begin
                if (btn_add) minutes_d = next_minutes(minutes_q, MIN_MAX);
                if (btn_set || btn_start) begin
                    state_d = S_READY;
                    load_d  = 1'b1;
                end
            end
            S_READY: begin
                if (btn_p1) begin
                    state_d = S_RUN_P2;
                end else if (btn_p2) begin
                    state_d = S_RUN_P1;
                end else if (btn_set) begin
                    state_d = S_SET;
                end
            end
            // Running clock hitting zero outranks any button in the same cycle.
            S_RUN_P1: begin
                if (zero1) begin
                    state_d = S_FLAG;
                    flag_d  = P_ONE;
                end else if (btn_p1) begin
                    state_d = S_RUN_P2;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                    saved_d = P_ONE;
                end
            end
            S_RUN_P2: begin
                if (zero2) begin
                    state_d = S_FLAG;
                    flag_d  = P_TWO;
                end else if (btn_p2) begin
                    state_d = S_RUN_P1;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                    saved_d = P_TWO;
                end
            end
            S_PAUSE: begin
                if (btn_start) begin
                    state_d = (saved_q == P_TWO) ? S_RUN_P2 : S_RUN_P1;
                end else if (btn_set) begin
                    state_d = S_SET;
                end
            end
            S_FLAG: begin
                if (btn_set) begin
                    state_d = S_SET;
                    flag_d  = P_NONE;
                end else if (btn_start) begin
                    state_d = S_READY;
                    flag_d  = P_NONE;
                    load_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        player_d = P_NONE;
        if (state_d == S_RUN_P1) player_d = P_ONE;
        if (state_d == S_RUN_P2) player_d = P_TWO;
    end

    // Count only while staying in the same RUN state; every RUN entry restarts the second.
    assign pre_run   = is_run(state_q) && (state_d == state_q);
    assign pre_clear = is_run(state_d) && (state_d != state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            minutes_q  <= MIN_RESET;
            flag_q     <= P_NONE;
            saved_q    <= P_NONE;
            player_q   <= P_NONE;
            load_q     <= 1'b0;
            set_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            minutes_q  <= minutes_d;
            flag_q     <= flag_d;
            saved_q    <= saved_d;
            player_q   <= player_d;
            load_q     <= load_d;
            set_mode_q <= (state_d == S_SET);
        end
    end

    sec_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick (
        .clk  (clk),
        .reset(reset),
        .run  (pre_run),
        .clear(pre_clear),
        .tick (tick)
    );

`ifdef CHESS_INCREMENT_EN
    logic [1:0] inc_q, inc_code;
    logic [7:0] inc_left_q;

    // inc names the player who just finished a move and earns the bonus.
    always_comb begin
        inc_code = P_NONE;
        if (state_q == S_RUN_P1 && state_d == S_RUN_P2) inc_code = P_ONE;
        if (state_q == S_RUN_P2 && state_d == S_RUN_P1) inc_code = P_TWO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_q      <= P_NONE;
            inc_left_q <= '0;
        end else if (inc_code != P_NONE && INC_SEC != 0) begin
            inc_q      <= inc_code;
            inc_left_q <= 8'(INC_SEC - 1);
        end else if (inc_left_q != 0) begin
            inc_left_q <= inc_left_q - 8'd1;
        end else begin
            inc_q <= P_NONE;
        end
    end

    assign inc = inc_q;
`endif

    assign state    = state_q;
    assign minutes  = minutes_q;
    assign flag     = flag_q;
    assign player   = player_q;
    assign load     = load_q;
    assign set_mode = set_mode_q;

endmodule
